reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  - Parametrised multi-lane register file for the superscalar pipeline; successor to the fixed 2-lane, 32x32 file.
//  - LANES issue lanes, each with 2 read ports and 1 write port.
//  - Adds a per-register busy scoreboard, set at issue and cleared at writeback, for hazard detection.
//  - Adds deterministic same-address write collision resolution and an optional write-to-read bypass.
//  - Sits between decode/issue (reads, reservations) and writeback (writes).
// PARAMETERS
//  LANES     2   number of issue lanes; lane 0 is oldest in program order
//  DW        32  data width in bits
//  DEPTH     32  number of architectural registers
//  AW        5   address width; must equal clog2(DEPTH)
//  ZERO_REG  1   1: register 0 is hardwired to zero, never written, never busy
// PORTS
//  clk       in   1          clock; all state updates on rising edge
//  reset     in   1          synchronous, active-high reset
//  rd_addr   in   LANES*2*AW read addresses; port p of lane l at slice [(2l+p)*AW +: AW]
//  rd_data   out  LANES*2*DW read data, same slicing with DW
//  rd_busy   out  LANES*2    1 = addressed register has an outstanding producer
//  wr_en     in   LANES      per-lane write enable
//  wr_addr   in   LANES*AW   per-lane write address
//  wr_data   in   LANES*DW   per-lane write data
//  rsv_en    in   LANES      per-lane destination reservation (issue)
//  rsv_addr  in   LANES*AW   per-lane reservation address
// BEHAVIOUR
//  - Reset (synchronous): at the reset edge all DEPTH registers clear to 0 and all busy bits clear to 0.
//    - While reset is high, writes and reservations are ignored.
//    - rd_data and rd_busy read 0 from the first reset edge on.
//    - Reset mid-operation discards pending writes and reservations in that cycle.
//  - Reads: combinational, zero-cycle latency from rd_addr to rd_data/rd_busy.
//    - Any number of ports may read the same address.
//  - Writes: committed at the rising edge when wr_en[l]=1.
//  - Write collision: two or more lanes write the same address in one cycle -> the highest-indexed
//    (youngest) lane's data is stored; the others are dropped.
//  - ZERO_REG=1:
//    - Writes and reservations to addr 0 are ignored.
//    - Reads of addr 0 return 0 with busy=0, including under bypass.
//  - Scoreboard, per register, updated at the edge:
//    - Set if any rsv_en[l] targets it.
//    - Cleared if any wr_en[l] targets it.
//    - Set and clear on the same register in the same cycle -> set wins (the new producer is younger).
//  - Issue logic guarantees at most one outstanding producer per register. This block does not count
//    producers.
//  - Out-of-range addresses (>= DEPTH when DEPTH < 2**AW):
//    - Writes and reservations are ignored.
//    - Reads return 0, busy=0.
// CONFIGURATION
//  - REG_FILE_BYPASS_EN defined (write-first):
//    - A read whose address matches an active same-cycle write returns that write's data
//      (highest matching lane wins).
//    - rd_busy for that port reads 0 unless a same-cycle reservation also targets the address.
//  - REG_FILE_BYPASS_EN undefined (read-before-write):
//    - Reads return pre-edge contents and pre-edge busy.
//    - New data is visible the cycle after the write edge.
// TESTING
//  1. Reset held 2 edges, release; read addrs 4..11 on all ports -> rd_data=0, rd_busy=0.
//  2. Lane0 wr r10=40 -> next cycle any port reading r10 gets 40.
//     Bypass build: 40 is visible in the same cycle.
//  3. Lane0 wr r15=60 and lane1 wr r25=70 in the same cycle -> both stored; reads return 60 and 70.
//  4. Lane0 wr r20=50 and lane1 wr r20=99 in the same cycle -> r20 reads 99.
//  5. Lane0 rsv r7 -> rd_busy for r7 = 1 next cycle.
//     - Lane1 wr r7=5 together with lane0 rsv r7 -> stays busy, r7=5.
//     - A subsequent lone wr to r7 -> busy=0.
//  6. Wr r0=123 and rsv r0 (ZERO_REG=1) -> r0 reads 0, busy 0.
//     Mid-sequence reset with r10=40 and r7 busy -> all registers 0, all busy 0 at the next edge.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-lane register file: LANES x (2 read, 1 write) ports, busy scoreboard.
// Optional write-first bypass when REG_FILE_BYPASS_EN is defined.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   rd_addr/rd_data      2 combinational read ports per lane, slice (2l+p)
//   rd_busy              1 = addressed register has an outstanding producer
//   wr_en/addr/data      1 write port per lane; youngest lane wins a collision
//   rsv_en/rsv_addr      per-lane destination reservation, sets busy
module reg_file_mp #(
  parameter int LANES    = 2,
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*2*AW-1:0]   rd_addr,
  output logic [LANES*2*DW-1:0]   rd_data,
  output logic [LANES*2-1:0]      rd_busy,
  input  logic [LANES-1:0]        wr_en,
  input  logic [LANES*AW-1:0]     wr_addr,
  input  logic [LANES*DW-1:0]     wr_data,
  input  logic [LANES-1:0]        rsv_en,
  input  logic [LANES*AW-1:0]     rsv_addr
);

  localparam int NP = LANES * 2;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic [LANES-1:0] wr_ok;
  logic [LANES-1:0] rsv_ok;

  // Storable address: inside the array and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic ok;
    ok = (32'(a) < 32'(DEPTH));
    if (ZERO_REG != 0 && a == '0) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Qualified per-lane write and reservation strobes.
  // Reset suppresses them, so the bypass also ignores writes under reset.
  always_comb begin
    wr_ok  = '0;
    rsv_ok = '0;
    for (int l = 0; l < LANES; l++) begin
      wr_ok[l]  = wr_en[l] && !reset &&
                  addr_ok(wr_addr[l*AW +: AW]);
      rsv_ok[l] = rsv_en[l] && !reset &&
                  addr_ok(rsv_addr[l*AW +: AW]);
    end
  end

  // Next state. Lanes are walked oldest to youngest so the youngest
  // colliding write lands last. Reservations are applied after all
  // clears so a same-cycle set beats a clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int l = 0; l < LANES; l++) begin
      if (wr_ok[l]) begin
        regs_d[wr_addr[l*AW +: AW]] = wr_data[l*DW +: DW];
        busy_d[wr_addr[l*AW +: AW]] = 1'b0;
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (rsv_ok[l]) begin
        busy_d[rsv_addr[l*AW +: AW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NP; p++) begin : g_rd
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          b;
`ifdef REG_FILE_BYPASS_EN
      logic          hit;
`endif
      a = rd_addr[p*AW +: AW];
      d = '0;
      b = 1'b0;
      if (addr_ok(a)) begin
        d = regs_q[a];
        b = busy_q[a];
`ifdef REG_FILE_BYPASS_EN
        hit = 1'b0;
        for (int l = 0; l < LANES; l++) begin
          if (wr_ok[l] && wr_addr[l*AW +: AW] == a) begin
            hit = 1'b1;
            d   = wr_data[l*DW +: DW];
          end
        end
        // A forwarded value retires the producer, unless a new one
        // is being reserved in the same cycle.
        if (hit) begin
          b = 1'b0;
          for (int l = 0; l < LANES; l++) begin
            if (rsv_ok[l] && rsv_addr[l*AW +: AW] == a) begin
              b = 1'b1;
            end
          end
        end
`endif
      end
      rd_data[p*DW +: DW] = d;
      rd_busy[p]          = b;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (LANES=2, 32x32).
// Expected values are hand-derived; bypass-dependent steps follow the macro.
module tb_reg_file_mp;

  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NP    = LANES * 2;

  logic                  clk;
  logic                  reset;
  logic [NP*AW-1:0]      rd_addr;
  logic [NP*DW-1:0]      rd_data;
  logic [NP-1:0]         rd_busy;
  logic [LANES-1:0]      wr_en;
  logic [LANES*AW-1:0]   wr_addr;
  logic [LANES*DW-1:0]   wr_data;
  logic [LANES-1:0]      rsv_en;
  logic [LANES*AW-1:0]   rsv_addr;

  int errors;
  int checks;

  reg_file_mp #(
    .LANES(LANES), .DW(DW), .DEPTH(DEPTH),
    .AW(AW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int l, input int a,
                    input int d);
    wr_en[l]              = 1'b1;
    wr_addr[l*AW +: AW]   = AW'(a);
    wr_data[l*DW +: DW]   = DW'(d);
  endtask

  task automatic rsv(input int l, input int a);
    rsv_en[l]             = 1'b1;
    rsv_addr[l*AW +: AW]  = AW'(a);
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = '0;
    rsv_addr = '0;
  endtask

  function automatic logic [31:0] dat(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  function automatic logic [31:0] bsy(input int p);
    return 32'(rd_busy[p]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    rd_addr = '0;
    idle();

    // 1. reset for two edges, then all reads zero
    tick();
    tick();
    reset = 1'b0;
    for (int base = 4; base < 12; base += NP) begin
      for (int p = 0; p < NP; p++) set_rd(p, base + p);
      #1;
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rst_data_r%0d", base + p), dat(p), 0);
        chk($sformatf("rst_busy_r%0d", base + p), bsy(p), 0);
      end
    end

    // 2. single write, visible on every port
    for (int p = 0; p < NP; p++) set_rd(p, 10);
    wr(0, 10, 40);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("wr_r10_same_cycle", dat(0), 40);
`else
    chk("wr_r10_same_cycle", dat(0), 0);
`endif
    tick();
    idle();
    #1;
    for (int p = 0; p < NP; p++)
      chk($sformatf("wr_r10_p%0d", p), dat(p), 40);

    // 3. two lanes, distinct addresses
    wr(0, 15, 60);
    wr(1, 25, 70);
    tick();
    idle();
    set_rd(0, 15);
    set_rd(1, 25);
    #1;
    chk("dual_wr_r15", dat(0), 60);
    chk("dual_wr_r25", dat(1), 70);

    // 4. collision: youngest lane wins
    wr(0, 20, 50);
    wr(1, 20, 99);
    tick();
    idle();
    set_rd(2, 20);
    #1;
    chk("collide_r20", dat(2), 99);

    // 5. scoreboard set / set-wins / clear
    set_rd(0, 7);
    rsv(0, 7);
    tick();
    idle();
    #1;
    chk("rsv_r7_busy", bsy(0), 1);
    rsv(0, 7);
    wr(1, 7, 5);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("setwin_bypass_busy", bsy(0), 1);
`else
    chk("setwin_pre_busy", bsy(0), 1);
`endif
    tick();
    idle();
    #1;
    chk("setwin_busy", bsy(0), 1);
    chk("setwin_data", dat(0), 5);
    wr(0, 7, 8);
    tick();
    idle();
    #1;
    chk("clear_busy", bsy(0), 0);
    chk("clear_data", dat(0), 8);

    // 6. zero register ignores write and reservation
    set_rd(1, 0);
    wr(0, 0, 123);
    rsv(1, 0);
    #1;
    chk("r0_data_now", dat(1), 0);
    chk("r0_busy_now", bsy(1), 0);
    tick();
    idle();
    #1;
    chk("r0_data", dat(1), 0);
    chk("r0_busy", bsy(1), 0);

    // mid-sequence reset with r10=40 and r7 busy
    rsv(0, 7);
    tick();
    idle();
    set_rd(0, 10);
    set_rd(1, 7);
    #1;
    chk("pre_rst_r10", dat(0), 40);
    chk("pre_rst_r7_busy", bsy(1), 1);
    reset = 1'b1;
    wr(0, 3, 77);
    rsv(1, 9);
    tick();
    reset = 1'b0;
    idle();
    set_rd(2, 3);
    set_rd(3, 9);
    #1;
    chk("mid_rst_r10", dat(0), 0);
    chk("mid_rst_r7_busy", bsy(1), 0);
    chk("mid_rst_r3_data", dat(2), 0);
    chk("mid_rst_r9_busy", bsy(3), 0);
    set_rd(0, 25);
    set_rd(1, 20);
    #1;
    chk("mid_rst_r25", dat(0), 0);
    chk("mid_rst_r20", dat(1), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
